// File: rtl/keypad_sprite_mover.sv
// rtl/keypad_sprite_mover.sv - keypad-driven sprite mover on a tile grid
// Optional diagonal stepping when KEYPAD_MOVER_DIAG_EN is defined.
module keypad_sprite_mover #(
    parameter int          COLS        = 80,
    parameter int          ROWS        = 30,
    parameter int          ADDR_W      = 12,
    parameter int          START_COL   = 10,
    parameter int          START_ROW   = 10,
    parameter logic [15:0] SPRITE_TILE = 16'h0e01,
    parameter logic [15:0] BG_TILE     = 16'h0000,
    parameter int          STEP_DELAY  = 100,
    parameter int          WRAP        = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       timer,
    input  logic [7:0]        keypad,
    output logic [ADDR_W-1:0] vga_addr,
    output logic              vga_we,
    output logic [15:0]       vga_data,
    output logic              busy,
    output logic [6:0]        col,
    output logic [6:0]        row
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        DRAW  = 3'd1,
        IDLE  = 3'd2,
        CALC  = 3'd3,
        ERASE = 3'd4,
        PLACE = 3'd5,
        HOLD  = 3'd6
    } state_t;

    localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
    localparam logic [6:0]  ROW_MAX   = 7'(ROWS - 1);
    localparam logic [6:0]  COL_START = 7'(START_COL);
    localparam logic [6:0]  ROW_START = 7'(START_ROW);
    localparam logic [31:0] DELAY     = 32'(STEP_DELAY);

    state_t            state;
    state_t            state_next;
    logic [3:0]        key_q;
    logic [31:0]       t0;
    logic [ADDR_W-1:0] old_addr;
    logic [6:0]        next_col;
    logic [6:0]        next_row;
    logic [31:0]       addr_full;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       elapsed;
    logic              moved;
    logic              unused_bits;

    function automatic logic [6:0] step_dec(input logic [6:0] v, input logic [6:0] max_v);
        if (v == 7'd0) begin
            return (WRAP != 0) ? max_v : 7'd0;
        end
        return v - 7'd1;
    endfunction

    function automatic logic [6:0] step_inc(input logic [6:0] v, input logic [6:0] max_v);
        if (v == max_v) begin
            return (WRAP != 0) ? 7'd0 : v;
        end
        return v + 7'd1;
    endfunction

    assign addr_full   = 32'(row) * 32'(COLS) + 32'(col);
    assign cur_addr    = addr_full[ADDR_W-1:0];
    assign elapsed     = timer - t0;
    assign unused_bits = ^{keypad[7:4], addr_full[31:ADDR_W]};

    // Candidate position from the key snapshot taken while IDLE.
    always_comb begin
        next_col = col;
        next_row = row;
`ifdef KEYPAD_MOVER_DIAG_EN
        if (key_q[0]) begin
            next_col = step_dec(col, COL_MAX);
        end else if (key_q[1]) begin
            next_col = step_inc(col, COL_MAX);
        end
        if (key_q[2]) begin
            next_row = step_inc(row, ROW_MAX);
        end else if (key_q[3]) begin
            next_row = step_dec(row, ROW_MAX);
        end
`else
        if (key_q[0]) begin
            next_col = step_dec(col, COL_MAX);
        end else if (key_q[1]) begin
            next_col = step_inc(col, COL_MAX);
        end else if (key_q[2]) begin
            next_row = step_inc(row, ROW_MAX);
        end else if (key_q[3]) begin
            next_row = step_dec(row, ROW_MAX);
        end
`endif
    end

    assign moved = (next_col != col) || (next_row != row);

    // Write outputs decode straight from state so reset kills a strobe at once.
    always_comb begin
        state_next = state;
        vga_we     = 1'b0;
        vga_addr   = '0;
        vga_data   = 16'h0000;
        busy       = 1'b1;
        case (state)
            INIT: begin
                state_next = DRAW;
            end
            DRAW: begin
                vga_we     = 1'b1;
                vga_addr   = cur_addr;
                vga_data   = SPRITE_TILE;
                state_next = IDLE;
            end
            IDLE: begin
                busy = 1'b0;
                if (keypad[3:0] != 4'b0000) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = moved ? ERASE : HOLD;
            end
            ERASE: begin
                vga_we     = 1'b1;
                vga_addr   = old_addr;
                vga_data   = BG_TILE;
                state_next = PLACE;
            end
            PLACE: begin
                vga_we     = 1'b1;
                vga_addr   = cur_addr;
                vga_data   = SPRITE_TILE;
                state_next = HOLD;
            end
            HOLD: begin
                if (elapsed >= DELAY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // col/row take the new position when CALC ends, so PLACE addresses it directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            col      <= COL_START;
            row      <= ROW_START;
            t0       <= 32'd0;
            key_q    <= 4'b0000;
            old_addr <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                key_q <= keypad[3:0];
            end
            if (state == CALC) begin
                t0       <= timer;
                old_addr <= cur_addr;
                col      <= next_col;
                row      <= next_row;
            end
        end
    end

endmodule
